// File: rtl/inst_sequencer.sv
// Instruction sequencer: a host-filled FIFO of 32-bit words, replayed to the
// downstream controller one word per SLOT_CYCLES-cycle slot after a start pulse.
module inst_sequencer #(
  parameter int DEPTH       = 16,
  parameter int SLOT_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              inst_out,
  output logic [2:0]               slot_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, finish, last_slot, have_word;

  // Ready depends only on the registered level, so a pop cannot make room for a same-cycle push.
  assign wr_ready  = (fifo_level != LW'(DEPTH));
  assign push      = wr_valid & wr_ready;
  assign have_word = (fifo_level != '0);
  assign last_slot = (slot_cnt == 3'(SLOT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && have_word) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (last_slot) begin
          if (have_word) begin
            pop = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage carries no reset; flushing is done through the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inst_out   <= '0;
      slot_cnt   <= '0;
      issued_cnt <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == S_ISSUE);
      done       <= finish;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (pop)         inst_out <= mem[rd_ptr];
      else if (finish) inst_out <= '0;

      if (pop || finish)          slot_cnt <= '0;
      else if (state == S_ISSUE)  slot_cnt <= slot_cnt + 3'd1;

      if (pop) issued_cnt <= (state == S_IDLE) ? 16'd1 : issued_cnt + 16'd1;
    end
  end

endmodule
